// File: rtl/score_keeper.sv
// Purpose : game score keeper with BCD score, persistent high score and speed level.
// Latency : every output is registered; changes appear one cycle after the causing edge.
// Backpressure: none; start/collide are sampled as levels, tick_en is a one-cycle strobe.
//
// Ports:
//   clk, rst (sync, active-high)  - clock and reset
//   tick_en                       - movement strobe, advances score timing in RUN only
//   start, collide                - start/restart request, obstacle collision
//   score, high_score [15:0]      - 4-digit packed BCD, thousands in [15:12]
//   game_state [1:0]              - 00 IDLE, 01 RUN, 10 OVER
//   new_high                      - last completed game set a new high score
//   speed_level [2:0]             - difficulty 0..7, bumps each time the hundreds digit rolls
module score_keeper #(
   parameter int unsigned TICKS_PER_POINT = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_en,
   input  logic        start,
   input  logic        collide,
   output logic [15:0] score,
   output logic [15:0] high_score,
   output logic [1:0]  game_state,
   output logic        new_high,
   output logic [2:0]  speed_level
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      OVER = 2'b10
   } state_t;

   localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_POINT - 1);

   state_t      state;
   logic [7:0]  prescaler;
   logic [15:0] score_inc;
   logic        hund_step;
   logic        score_sat;
   logic        point_due;

   assign game_state = state;
   assign score_sat  = (score == 16'h9999);
   assign point_due  = tick_en && (prescaler == LAST_TICK);

   // Decimal ripple increment. hund_step flags that the hundreds digit
   // changes, which is exactly when the low two digits roll over from 99.
   always_comb begin
      score_inc = score;
      hund_step = 1'b0;
      if (score[3:0] != 4'd9) begin
         score_inc[3:0] = score[3:0] + 4'd1;
      end else begin
         score_inc[3:0] = 4'd0;
         if (score[7:4] != 4'd9) begin
            score_inc[7:4] = score[7:4] + 4'd1;
         end else begin
            score_inc[7:4] = 4'd0;
            hund_step      = 1'b1;
            if (score[11:8] != 4'd9) begin
               score_inc[11:8] = score[11:8] + 4'd1;
            end else begin
               score_inc[11:8] = 4'd0;
               if (score[15:12] != 4'd9) begin
                  score_inc[15:12] = score[15:12] + 4'd1;
               end else begin
                  score_inc[15:12] = 4'd0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         score       <= 16'h0000;
         high_score  <= 16'h0000;
         prescaler   <= 8'd0;
         speed_level <= 3'd0;
         new_high    <= 1'b0;
      end else begin
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  state       <= RUN;
                  score       <= 16'h0000;
                  prescaler   <= 8'd0;
                  speed_level <= 3'd0;
                  new_high    <= 1'b0;
               end
            end
            RUN: begin
               // Collision takes precedence over a point that is due this edge.
               if (collide) begin
                  state <= OVER;
                  // Packed BCD sorts the same as its numeric value.
                  if (score > high_score) begin
                     high_score <= score;
                     new_high   <= 1'b1;
                  end
               end else if (tick_en) begin
                  if (point_due) begin
                     prescaler <= 8'd0;
                     if (!score_sat) begin
                        score <= score_inc;
                        if (hund_step && (speed_level != 3'd7)) begin
                           speed_level <= speed_level + 3'd1;
                        end
                     end
                  end else begin
                     prescaler <= prescaler + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
